// File: rtl/mem_arbiter.sv
// Shared-bus arbiter: N PicoRV32 look-ahead request ports onto one valid/ready bus,
// round-robin or fixed priority, one transaction in flight, registered mem_ready pulse.

module mem_arbiter_slot (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        clr,
    output logic        req,
    output logic        cur_we,
    output logic [31:0] cur_addr,
    output logic [31:0] cur_wdata,
    output logic [3:0]  cur_wstrb
);
    logic        pend_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (clr) begin
            pend_q <= 1'b0;
        end else if ((rd | wr) && !pend_q) begin
            pend_q  <= 1'b1;
            we_q    <= wr;
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // A fresh pulse is visible to arbitration in its own cycle, so an idle
    // arbiter grants on the capture edge and matches picorv32 read latency.
    assign req       = pend_q | rd | wr;
    assign cur_we    = pend_q ? we_q    : wr;
    assign cur_addr  = pend_q ? addr_q  : addr;
    assign cur_wdata = pend_q ? wdata_q : wdata;
    assign cur_wstrb = pend_q ? wstrb_q : wstrb;
endmodule

module mem_arbiter #(
    parameter int   N_PORTS    = 4,
    parameter int   MEM_W      = 32,
    parameter int   FIXED_PRIO = 0,
    localparam int  PW         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_PORTS-1:0]     la_read,
    input  logic [N_PORTS-1:0]     la_write,
    input  logic [32*N_PORTS-1:0]  la_addr,
    input  logic [32*N_PORTS-1:0]  la_wdata,
    input  logic [4*N_PORTS-1:0]   la_wstrb,
    output logic [N_PORTS-1:0]     mem_ready,
    output logic [32*N_PORTS-1:0]  mem_rdata,
    output logic                   bus_valid,
    output logic                   bus_we,
    output logic [MEM_W-1:0]       bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [3:0]             bus_wstrb,
    output logic [PW-1:0]          bus_id,
    input  logic [31:0]            bus_rdata,
    input  logic                   bus_ready
);
    typedef enum logic {IDLE, BUS} state_t;

    state_t                    state, state_d;
    logic [N_PORTS-1:0]        req, cur_we, done_vec;
    logic [N_PORTS-1:0][31:0]  cur_addr, cur_wdata;
    logic [N_PORTS-1:0][3:0]   cur_wstrb;
    logic [PW-1:0]             last, win, hi_win, lo_win;
    logic                      hi_found, lo_found;
    logic                      grant, done;
    logic                      sel_we;
    logic [31:0]               sel_addr, sel_wdata;
    logic [3:0]                sel_wstrb;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_slot
        mem_arbiter_slot u_slot (
            .clk       (clk),
            .resetn    (resetn),
            .rd        (la_read[gi]),
            .wr        (la_write[gi]),
            .addr      (la_addr[32*gi +: 32]),
            .wdata     (la_wdata[32*gi +: 32]),
            .wstrb     (la_wstrb[4*gi +: 4]),
            .clr       (done_vec[gi]),
            .req       (req[gi]),
            .cur_we    (cur_we[gi]),
            .cur_addr  (cur_addr[gi]),
            .cur_wdata (cur_wdata[gi]),
            .cur_wstrb (cur_wstrb[gi])
        );
        assign done_vec[gi] = done && (bus_id == PW'(gi));
    end

    // Round-robin = first requester above last, else first requester overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (req[i] && !lo_found) begin
                lo_win   = PW'(i);
                lo_found = 1'b1;
            end
            if (req[i] && !hi_found && i > int'(last)) begin
                hi_win   = PW'(i);
                hi_found = 1'b1;
            end
        end
        win = (FIXED_PRIO == 0 && hi_found) ? hi_win : lo_win;
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (win == PW'(i)) begin
                sel_we    = cur_we[i];
                sel_addr  = cur_addr[i];
                sel_wdata = cur_wdata[i];
                sel_wstrb = cur_wstrb[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        grant   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (|req) begin
                grant   = 1'b1;
                state_d = BUS;
            end
            BUS: if (bus_valid && bus_ready) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            bus_id    <= '0;
            mem_ready <= '0;
            mem_rdata <= '0;
            last      <= PW'(N_PORTS - 1);
        end else begin
            mem_ready <= done_vec;
            if (grant) begin
                bus_valid <= 1'b1;
                bus_we    <= sel_we;
                bus_addr  <= sel_addr[MEM_W-1:0];
                bus_wdata <= sel_wdata;
                bus_wstrb <= sel_we ? sel_wstrb : 4'b0000;
                bus_id    <= win;
                last      <= win;
            end
            if (done) begin
                bus_valid <= 1'b0;
                if (!bus_we) begin
                    for (int i = 0; i < N_PORTS; i++)
                        if (done_vec[i]) mem_rdata[32*i +: 32] <= bus_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin, fixed-priority and single-port builds.

module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // round-robin, 4 ports
    logic [3:0]   rr_rd = '0, rr_wr = '0;
    logic [127:0] rr_addr = '0, rr_wdata = '0;
    logic [15:0]  rr_wstrb = '0;
    logic         rr_rdy = 1'b0;
    logic [31:0]  rr_brdata = '0;
    logic [3:0]   rr_mready;
    logic [127:0] rr_mrdata;
    logic         rr_bvalid, rr_bwe;
    logic [31:0]  rr_baddr, rr_bwdata;
    logic [3:0]   rr_bwstrb;
    logic [1:0]   rr_bid;

    // fixed priority, 4 ports
    logic [3:0]   fp_rd = '0, fp_wr = '0;
    logic [127:0] fp_addr = '0, fp_wdata = '0;
    logic [15:0]  fp_wstrb = '0;
    logic         fp_rdy = 1'b0;
    logic [31:0]  fp_brdata = '0;
    logic [3:0]   fp_mready;
    logic [127:0] fp_mrdata;
    logic         fp_bvalid, fp_bwe;
    logic [31:0]  fp_baddr, fp_bwdata;
    logic [3:0]   fp_bwstrb;
    logic [1:0]   fp_bid;

    // single port
    logic         one_rd = 1'b0, one_wr = 1'b0;
    logic [31:0]  one_addr = '0, one_wdata = '0;
    logic [3:0]   one_wstrb = '0;
    logic         one_rdy = 1'b0;
    logic [31:0]  one_brdata = '0;
    logic         one_mready;
    logic [31:0]  one_mrdata;
    logic         one_bvalid, one_bwe;
    logic [31:0]  one_baddr, one_bwdata;
    logic [3:0]   one_bwstrb;
    logic [0:0]   one_bid;

    mem_arbiter #(.N_PORTS(4), .MEM_W(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .resetn(resetn), .la_read(rr_rd), .la_write(rr_wr), .la_addr(rr_addr),
        .la_wdata(rr_wdata), .la_wstrb(rr_wstrb), .mem_ready(rr_mready), .mem_rdata(rr_mrdata),
        .bus_valid(rr_bvalid), .bus_we(rr_bwe), .bus_addr(rr_baddr), .bus_wdata(rr_bwdata),
        .bus_wstrb(rr_bwstrb), .bus_id(rr_bid), .bus_rdata(rr_brdata), .bus_ready(rr_rdy));

    mem_arbiter #(.N_PORTS(4), .MEM_W(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .resetn(resetn), .la_read(fp_rd), .la_write(fp_wr), .la_addr(fp_addr),
        .la_wdata(fp_wdata), .la_wstrb(fp_wstrb), .mem_ready(fp_mready), .mem_rdata(fp_mrdata),
        .bus_valid(fp_bvalid), .bus_we(fp_bwe), .bus_addr(fp_baddr), .bus_wdata(fp_bwdata),
        .bus_wstrb(fp_bwstrb), .bus_id(fp_bid), .bus_rdata(fp_brdata), .bus_ready(fp_rdy));

    mem_arbiter #(.N_PORTS(1), .MEM_W(32), .FIXED_PRIO(0)) u_one (
        .clk(clk), .resetn(resetn), .la_read(one_rd), .la_write(one_wr), .la_addr(one_addr),
        .la_wdata(one_wdata), .la_wstrb(one_wstrb), .mem_ready(one_mready), .mem_rdata(one_mrdata),
        .bus_valid(one_bvalid), .bus_we(one_bwe), .bus_addr(one_baddr), .bus_wdata(one_bwdata),
        .bus_wstrb(one_bwstrb), .bus_id(one_bid), .bus_rdata(one_brdata), .bus_ready(one_rdy));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each row: inputs for one cycle -> outputs visible after the following edge.
    typedef struct {
        logic         rst;
        logic [3:0]   rd;
        logic [31:0]  rdata;
        logic         e_valid;
        logic [1:0]   e_id;
        logic [31:0]  e_addr;
        logic [3:0]   e_ready;
        logic [127:0] e_mrdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] rd, input logic [31:0] rdata,
                                input logic e_valid, input logic [1:0] e_id, input logic [31:0] e_addr,
                                input logic [3:0] e_ready, input logic [127:0] e_mrdata);
        vec_t v;
        v.rst = rst; v.rd = rd; v.rdata = rdata; v.e_valid = e_valid; v.e_id = e_id;
        v.e_addr = e_addr; v.e_ready = e_ready; v.e_mrdata = e_mrdata;
        return v;
    endfunction

    localparam logic [127:0] M_BEEF = {32'h0, 32'hDEADBEEF, 64'h0};
    localparam logic [127:0] M_1    = {96'h0, 32'h11111111};
    localparam logic [127:0] M_2    = {64'h0, 32'h22222222, 32'h11111111};
    localparam logic [127:0] M_3    = {32'h0, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] M_4    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] M_5    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h55555555};

    initial begin
        // single read on port 2
        tbl.push_back(mk(0, 4'b0100, 32'h0,        1, 2, 32'h010, 4'b0000, 128'h0));
        tbl.push_back(mk(0, 4'b0000, 32'hDEADBEEF, 0, 0, 32'h0,   4'b0100, M_BEEF));
        tbl.push_back(mk(0, 4'b0000, 32'h0,        0, 0, 32'h0,   4'b0000, M_BEEF));
        // reset, then all four ports at once; port 0 re-requests after its ready
        tbl.push_back(mk(1, 4'b0000, 32'h0,        0, 0, 32'h0,   4'b0000, 128'h0));
        tbl.push_back(mk(0, 4'b1111, 32'h0,        1, 0, 32'h400, 4'b0000, 128'h0));
        tbl.push_back(mk(0, 4'b0000, 32'h11111111, 0, 0, 32'h0,   4'b0001, M_1));
        tbl.push_back(mk(0, 4'b0001, 32'h0,        1, 1, 32'h800, 4'b0000, M_1));
        tbl.push_back(mk(0, 4'b0000, 32'h22222222, 0, 0, 32'h0,   4'b0010, M_2));
        tbl.push_back(mk(0, 4'b0000, 32'h0,        1, 2, 32'h010, 4'b0000, M_2));
        tbl.push_back(mk(0, 4'b0000, 32'h33333333, 0, 0, 32'h0,   4'b0100, M_3));
        tbl.push_back(mk(0, 4'b0000, 32'h0,        1, 3, 32'hC00, 4'b0000, M_3));
        tbl.push_back(mk(0, 4'b0000, 32'h44444444, 0, 0, 32'h0,   4'b1000, M_4));
        tbl.push_back(mk(0, 4'b0000, 32'h0,        1, 0, 32'h400, 4'b0000, M_4));
        tbl.push_back(mk(0, 4'b0000, 32'h55555555, 0, 0, 32'h0,   4'b0001, M_5));
        tbl.push_back(mk(0, 4'b0000, 32'h0,        0, 0, 32'h0,   4'b0000, M_5));

        rr_addr = {32'h00000C00, 32'h00000010, 32'h00000800, 32'h00000400};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst rr valid", rr_bvalid, 0);
        chk("rst rr we", rr_bwe, 0);
        chk("rst rr addr", rr_baddr, 0);
        chk("rst rr wdata", rr_bwdata, 0);
        chk("rst rr wstrb", rr_bwstrb, 0);
        chk("rst rr id", rr_bid, 0);
        chk("rst rr mready", rr_mready, 0);
        chk("rst rr mrdata", rr_mrdata, 0);
        chk("rst fp valid", fp_bvalid, 0);
        chk("rst one valid", one_bvalid, 0);
        chk("rst one mready", one_mready, 0);
        resetn = 1'b1;
        rr_rdy = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            resetn = !tbl[k].rst;
            rr_rd = tbl[k].rd;
            rr_brdata = tbl[k].rdata;
            @(negedge clk);
            chk($sformatf("row%0d valid", k), rr_bvalid, tbl[k].e_valid);
            if (tbl[k].e_valid) begin
                chk($sformatf("row%0d id", k), rr_bid, tbl[k].e_id);
                chk($sformatf("row%0d we", k), rr_bwe, 0);
                chk($sformatf("row%0d wstrb", k), rr_bwstrb, 0);
                chk($sformatf("row%0d addr", k), rr_baddr, tbl[k].e_addr);
            end
            chk($sformatf("row%0d mready", k), rr_mready, tbl[k].e_ready);
            chk($sformatf("row%0d mrdata", k), rr_mrdata, tbl[k].e_mrdata);
        end
        resetn = 1'b1;
        rr_rd = '0;

        // write on port 1 with three bus wait states
        rr_rdy = 1'b0;
        rr_brdata = 32'hBAD0BAD0;
        rr_wdata[63:32] = 32'h12345678;
        rr_wstrb[7:4] = 4'b0011;
        rr_wr = 4'b0010;
        @(negedge clk);
        rr_wr = '0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("wr c%0d valid", c), rr_bvalid, 1);
            chk($sformatf("wr c%0d id", c), rr_bid, 1);
            chk($sformatf("wr c%0d we", c), rr_bwe, 1);
            chk($sformatf("wr c%0d addr", c), rr_baddr, 32'h800);
            chk($sformatf("wr c%0d wdata", c), rr_bwdata, 32'h12345678);
            chk($sformatf("wr c%0d wstrb", c), rr_bwstrb, 4'b0011);
            chk($sformatf("wr c%0d mready", c), rr_mready, 0);
            if (c == 3) rr_rdy = 1'b1;
            @(negedge clk);
        end
        chk("wr done valid", rr_bvalid, 0);
        chk("wr done mready", rr_mready, 4'b0010);
        chk("wr done mrdata", rr_mrdata, M_5);
        rr_rdy = 1'b0;
        @(negedge clk);
        chk("wr pulse end", rr_mready, 0);

        // reset while a read waits on the bus
        rr_rd = 4'b0100;
        @(negedge clk);
        rr_rd = '0;
        chk("rstbus valid", rr_bvalid, 1);
        chk("rstbus id", rr_bid, 2);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstbus dropped", rr_bvalid, 0);
        chk("rstbus no ready", rr_mready, 0);
        resetn = 1'b1;
        rr_rdy = 1'b1;
        rr_rd = 4'b1001;
        @(negedge clk);
        rr_rd = '0;
        chk("rstbus g0 valid", rr_bvalid, 1);
        chk("rstbus g0 id", rr_bid, 0);
        @(negedge clk);
        chk("rstbus g0 ready", rr_mready, 4'b0001);
        @(negedge clk);
        chk("rstbus g3 valid", rr_bvalid, 1);
        chk("rstbus g3 id", rr_bid, 3);
        @(negedge clk);
        chk("rstbus g3 ready", rr_mready, 4'b1000);
        @(negedge clk);
        chk("rstbus idle", rr_bvalid, 0);
        chk("rstbus idle ready", rr_mready, 0);
        rr_rdy = 1'b0;

        // fixed priority: port 1 keeps re-requesting, port 3 waits
        fp_addr = {32'h3333000C, 32'h0, 32'h11110004, 32'h0};
        fp_rdy = 1'b1;
        fp_rd = 4'b1010;
        @(negedge clk);
        fp_rd = '0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fp g%0d valid", k), fp_bvalid, 1);
            chk($sformatf("fp g%0d id", k), fp_bid, 1);
            chk($sformatf("fp g%0d addr", k), fp_baddr, 32'h11110004);
            @(negedge clk);
            chk($sformatf("fp g%0d ready", k), fp_mready, 4'b0010);
            if (k < 2) fp_rd = 4'b0010;
            @(negedge clk);
            fp_rd = '0;
        end
        chk("fp p3 valid", fp_bvalid, 1);
        chk("fp p3 id", fp_bid, 3);
        chk("fp p3 addr", fp_baddr, 32'h3333000C);
        @(negedge clk);
        chk("fp p3 ready", fp_mready, 4'b1000);
        fp_rdy = 1'b0;

        // single-port build, back-to-back read then write
        one_rdy = 1'b1;
        one_brdata = 32'hCAFEF00D;
        one_addr = 32'h40;
        one_rd = 1'b1;
        @(negedge clk);
        one_rd = 1'b0;
        chk("one rd valid", one_bvalid, 1);
        chk("one rd id", one_bid, 0);
        chk("one rd we", one_bwe, 0);
        @(negedge clk);
        chk("one rd ready", one_mready, 1);
        chk("one rd data", one_mrdata, 32'hCAFEF00D);
        one_brdata = 32'h0BADBAD0;
        one_wdata = 32'hA5A5A5A5;
        one_wstrb = 4'b1111;
        one_wr = 1'b1;
        @(negedge clk);
        one_wr = 1'b0;
        chk("one wr valid", one_bvalid, 1);
        chk("one wr id", one_bid, 0);
        chk("one wr we", one_bwe, 1);
        chk("one wr wstrb", one_bwstrb, 4'b1111);
        chk("one wr ready low", one_mready, 0);
        @(negedge clk);
        chk("one wr ready", one_mready, 1);
        chk("one wr data kept", one_mrdata, 32'hCAFEF00D);
        @(negedge clk);
        chk("one idle", one_bvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-bus arbiter connecting N_PORTS PicoRV32 look-ahead memory interfaces to one downstream variable-latency bus. It captures each core's single-cycle `mem_la_*` request, arbitrates work-conserving round-robin (or fixed priority), issues one transaction at a time with a valid/ready handshake, and returns a registered one-cycle `mem_ready` pulse with read data to the issuing core. It sits between the core array and the address decoder / BRAM / peripheral fabric in the multicore top.

## Interface
- N_PORTS, 4, number of cores, 1..16
- MEM_W, 32, address width forwarded downstream
- FIXED_PRIO, 0, 0 = round-robin skipping idle ports; 1 = lowest index wins
- PW, derived, pointer width = max(1, $clog2(N_PORTS))

- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- la_read  in  N_PORTS  per-port read request pulse (mem_la_read)
- la_write  in  N_PORTS  per-port write request pulse (mem_la_write)
- la_addr  in  32*N_PORTS  packed addresses, port i at [32i+31:32i]
- la_wdata  in  32*N_PORTS  packed write data
- la_wstrb  in  4*N_PORTS  packed byte strobes
- mem_ready  out  N_PORTS  one-cycle completion pulse per port
- mem_rdata  out  32*N_PORTS  packed read data, valid with mem_ready
- bus_valid  out  1  downstream request valid
- bus_we  out  1  1 = write
- bus_addr  out  MEM_W  downstream address (la_addr[MEM_W-1:0])
- bus_wdata  out  32  write data
- bus_wstrb  out  4  byte strobes (forced 0 for reads)
- bus_id  out  PW  index of granted port, stable while bus_valid
- bus_rdata  in  32  read data, sampled when bus_valid && bus_ready
- bus_ready  in  1  downstream accept/complete, may be high in the same cycle as bus_valid

## Operation
- Per-port capture: on an edge where la_read[i] | la_write[i], store pend[i]=1, we[i]=la_write[i], addr/wdata/wstrb. Both read and write high: treat as write. A pulse on a port with pend[i]=1 is ignored (protocol violation, cores never issue it).
- States: IDLE, BUS.
  - IDLE: if any pend, select winner, load bus_* from its slot, bus_id=winner, bus_valid<=1, -> BUS. Otherwise stay.
  - BUS: hold all bus_* stable. On bus_valid && bus_ready: bus_valid<=0, pend[bus_id]<=0, mem_ready[bus_id]<=1, mem_rdata lane bus_id <= bus_rdata if read (unchanged for writes), -> IDLE.
- Round-robin: pointer last (reset N_PORTS-1); search last+1, last+2 ... modulo N_PORTS, first pend wins; last<=winner on grant. Idle ports are skipped with no lost cycle.
- FIXED_PRIO=1: lowest-index pending port wins; pointer is unused.
- Capture in the same edge as the grant of a different port: both take effect. Capture on the same port as the completion edge cannot occur; if it does, completion (clear) takes precedence.
- mem_ready is a pulse: low on every cycle except the one following completion. Non-winning rdata lanes hold their values.

## Timing
- Reset (synchronous, resetn=0 at edge): state IDLE, pend=0, bus_valid=0, bus_we=0, bus_addr/wdata/wstrb=0, bus_id=0, mem_ready=0, mem_rdata=0, last=N_PORTS-1. Reset mid-BUS drops the transaction regardless of bus_ready; no mem_ready is issued.
- Minimum latency with an idle arbiter and zero-wait bus_ready: la pulse in cycle 0 -> pend set at edge 1 -> bus_valid high cycle 1 -> (bus_ready high) completion at edge 2 -> mem_ready high cycle 2, same cycle index as picorv32 reads.
- Throughput: one transaction per 2 cycles with zero-wait downstream; each bus wait state adds 1 cycle.
- Worst-case wait per port with all ports busy in round-robin: (N_PORTS-1) transactions.

## Test plan
- Single read, N_PORTS=4: la_read[2] pulse with addr 0x0000_0010 and bus_ready tied 1 -> bus_valid 1 cycle later with bus_id=2, bus_we=0, bus_wstrb=0; bus_rdata=0xDEADBEEF -> mem_ready=4'b0100 for exactly one cycle, lane 2=0xDEADBEEF, other lanes unchanged.
- All four ports pulse in the same cycle, round-robin, ready=1 -> grants in order 0,1,2,3, one every 2 cycles; new pulse on port 0 after its ready -> next grant 0 only after 1,2,3.
- FIXED_PRIO=1, ports 1 and 3 pending and port 1 re-requesting immediately after each completion -> port 3 starves while port 1 keeps requesting; grants 1,1,1...
- Write with 3 bus wait states: la_write[1], wdata 0x12345678, wstrb 4'b0011 -> bus_* stable for 4 cycles, bus_we=1; mem_ready[1] pulses 1 cycle after the handshake; mem_rdata lane 1 unchanged.
- Reset asserted while in BUS with bus_ready low -> next cycle bus_valid=0, no mem_ready; after release, a fresh request on port 0 is granted first.
- N_PORTS=1 build: back-to-back requests complete with 2-cycle spacing, bus_id always 0.
